// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer and its next-PC mux.
// Holds the PC width, the FSM state encoding and the {s2,s1} select codes.
package pc_sequencer_pkg;

  localparam int unsigned PC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  // Next-PC mux select codes, packed as {s2,s1}
  typedef enum logic [1:0] {
    SEL_INC = 2'b00,
    SEL_BR  = 2'b01,
    SEL_JMP = 2'b10,
    SEL_RST = 2'b11
  } pc_sel_t;

endpackage

// File: rtl/pc_sequencer_muxpc.sv
// Next-PC selector: picks increment, branch, jump or reset vector.
// Ports:
//   s1, s2     : select bits, {s2,s1} decoded as pc_sel_t
//   inc_pc     : pc + step
//   br_target  : branch destination
//   jmp_target : jump destination
//   reset_pc   : reset vector
//   next_pc    : selected next program counter
module pc_sequencer_muxpc
  import pc_sequencer_pkg::*;
(
  input  logic            s1,
  input  logic            s2,
  input  logic [PC_W-1:0] inc_pc,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] jmp_target,
  input  logic [PC_W-1:0] reset_pc,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = inc_pc;
    case (pc_sel_t'({s2, s1}))
      SEL_INC: next_pc = inc_pc;
      SEL_BR:  next_pc = br_target;
      SEL_JMP: next_pc = jmp_target;
      SEL_RST: next_pc = reset_pc;
      default: next_pc = inc_pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> EXEC loop with a HOLD state for
// execute stalls. The PC advances only when EXEC completes without a stall.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   imem_ready            : instruction memory completes the fetch this cycle
//   stall                 : execute-stage hold request
//   br_valid/taken/target : resolved conditional branch (EXEC only)
//   jmp_valid/target      : unconditional jump (EXEC only)
//   fetch_req             : fetch request, high only in FETCH
//   pc                    : registered program counter
//   s1, s2                : next-PC mux select bits
//   state                 : current FSM state (debug)
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  output logic            fetch_req,
  output logic [PC_W-1:0] pc,
  output logic            s1,
  output logic            s2,
  output logic [1:0]      state
);

  state_t          state_q;
  state_t          state_nxt;
  pc_sel_t         sel;
  logic            pc_load;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] inc_pc;
  logic [PC_W-1:0] next_pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic; stall wins over any redirect in EXEC
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (imem_ready) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = stall ? ST_HOLD : ST_FETCH;
      ST_HOLD:  if (!stall) state_nxt = ST_EXEC;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: fetch request, mux select and PC load enable
  always_comb begin
    fetch_req = (state_q == ST_FETCH);
    sel       = SEL_INC;
    pc_load   = 1'b0;
    if (rst) begin
      sel = SEL_RST;
    end else if (state_q == ST_EXEC && !stall) begin
      pc_load = 1'b1;
      if (jmp_valid)                 sel = SEL_JMP;
      else if (br_valid && br_taken) sel = SEL_BR;
      else                           sel = SEL_INC;
    end
  end

  // Wraps modulo 2^16; the carry is deliberately dropped
  assign inc_pc = PC_W'(pc_q + PC_STEP);

  pc_sequencer_muxpc u_muxpc (
    .s1         (sel[0]),
    .s2         (sel[1]),
    .inc_pc     (inc_pc),
    .br_target  (br_target),
    .jmp_target (jmp_target),
    .reset_pc   (RESET_PC),
    .next_pc    (next_pc)
  );

  // PC register
  always_ff @(posedge clk) begin
    if (rst)          pc_q <= RESET_PC;
    else if (pc_load) pc_q <= next_pc;
  end

  assign pc    = pc_q;
  assign s1    = sel[0];
  assign s2    = sel[1];
  assign state = state_q;

endmodule
